// File: rtl/quad_encoder_bank.sv
`default_nettype none
// ============================================================================
// Module   : quad_encoder_bank
// Purpose  : Multi-channel quadrature encoder decoder. Each channel runs a
//            2-flop synchroniser, a per-bit glitch filter, and a Gray-code
//            quarter-step decoder with x1 (per detent) or x4 (per edge)
//            resolution. It also keeps an up/down value per channel.
// Options  : define QENC_SATURATE_EN to clamp values instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module quad_encoder_bank #(
  parameter int          NUM_CH        = 3,
  parameter int          OUT_WIDTH     = 8,
  parameter int unsigned STEP          = 1,
  parameter int          FILTER_CYCLES = 4,
  parameter int          X4_MODE       = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             a,
  input  logic [NUM_CH-1:0]             b,
  input  logic [NUM_CH-1:0]             clear,
  output logic [NUM_CH*OUT_WIDTH-1:0]   value,
  output logic [NUM_CH-1:0]             changed,
  output logic [NUM_CH-1:0]             dir,
  output logic [NUM_CH-1:0]             error
);

  localparam logic [OUT_WIDTH-1:0] c_STEP = OUT_WIDTH'(STEP);
  // The filter counter only needs to reach FILTER_CYCLES-1 before the level flips.
  localparam int c_CW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
  localparam logic [c_CW-1:0] c_CNT_LAST = (FILTER_CYCLES < 1) ? '0 : c_CW'(FILTER_CYCLES - 1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]           r_sync1, r_sync2, r_prev;
    logic [1:0]           w_filt;
    logic [2:0]           r_q;
    logic [OUT_WIDTH-1:0] r_val;
    logic                 r_chg, r_dir, r_err;

    logic [1:0]           w_pidx, w_cidx;
    logic                 w_fwd, w_rev, w_bad, w_at0;
    logic [3:0]           w_qn;
    logic                 w_inc, w_dec, w_step;
    logic [2:0]           w_q_next;
    logic [OUT_WIDTH-1:0] w_up, w_dn, w_next;

    // Two-flop synchroniser for the asynchronous {A,B} pins.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_sync1 <= 2'b00;
        r_sync2 <= 2'b00;
      end else begin
        r_sync1 <= {a[i], b[i]};
        r_sync2 <= r_sync1;
      end
    end

    if (FILTER_CYCLES == 0) begin : g_nofilt
      assign w_filt = r_sync2;
    end else begin : g_filt
      for (genvar j = 0; j < 2; j++) begin : g_bit
        logic [c_CW-1:0] r_cnt;
        logic            r_lvl;

        // The level follows the synced bit only after it has differed for FILTER_CYCLES cycles in a row.
        always_ff @(posedge clk) begin
          if (reset) begin
            r_cnt <= '0;
            r_lvl <= 1'b0;
          end else if (r_sync2[j] == r_lvl) begin
            r_cnt <= '0;
          end else if (r_cnt == c_CNT_LAST) begin
            r_lvl <= r_sync2[j];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end

        assign w_filt[j] = r_lvl;
      end
    end

    // Positions along the forward cycle 00->10->11->01 are given by {B, A^B}.
    assign w_pidx = {r_prev[0], ^r_prev};
    assign w_cidx = {w_filt[0], ^w_filt};
    assign w_fwd  = (w_cidx == w_pidx + 2'd1);
    assign w_rev  = (w_cidx == w_pidx - 2'd1);
    assign w_bad  = (w_filt == ~r_prev);
    assign w_at0  = (w_filt == 2'b00);

    // Sign-extended quarter count after this cycle's step.
    assign w_qn = w_fwd ? ({r_q[2], r_q} + 4'd1) :
                  w_rev ? ({r_q[2], r_q} - 4'd1) : {r_q[2], r_q};

    // In x1 mode, only a full detent of four quarters in one direction counts.
    assign w_inc = (X4_MODE != 0) ? w_fwd : (w_fwd && w_at0 && (w_qn == 4'b0100));
    assign w_dec = (X4_MODE != 0) ? w_rev : (w_rev && w_at0 && (w_qn == 4'b1100));

    // Quarter counter restarts at each return to 00, on illegal jumps and on clear.
    always_comb begin
      w_q_next = r_q;
      if (clear[i] || w_bad || (w_at0 && (w_fwd || w_rev))) begin
        w_q_next = 3'b000;
      end else if (w_fwd || w_rev) begin
        w_q_next = w_qn[2:0];
      end
    end

`ifdef QENC_SATURATE_EN
    logic [OUT_WIDTH:0] w_sum, w_dif;
    assign w_sum  = {1'b0, r_val} + {1'b0, c_STEP};
    assign w_dif  = {1'b0, r_val} - {1'b0, c_STEP};
    assign w_up   = w_sum[OUT_WIDTH] ? '1 : w_sum[OUT_WIDTH-1:0];
    assign w_dn   = w_dif[OUT_WIDTH] ? '0 : w_dif[OUT_WIDTH-1:0];
    assign w_next = w_inc ? w_up : (w_dec ? w_dn : r_val);
    // A clamped step that leaves the value untouched is not reported.
    assign w_step = (w_inc || w_dec) && (w_next != r_val);
`else
    assign w_up   = r_val + c_STEP;
    assign w_dn   = r_val - c_STEP;
    assign w_next = w_inc ? w_up : (w_dec ? w_dn : r_val);
    assign w_step = w_inc || w_dec;
`endif

    // Channel state: previous {A,B}, quarter count, value and event pulses.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_prev <= 2'b00;
        r_q    <= 3'b000;
        r_val  <= '0;
        r_chg  <= 1'b0;
        r_dir  <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        r_prev <= w_filt;
        r_q    <= w_q_next;
        r_err  <= w_bad;
        if (clear[i]) begin
          r_val <= '0;
          r_chg <= 1'b0;
        end else begin
          r_chg <= w_step;
          if (w_step) begin
            r_val <= w_next;
            r_dir <= w_inc;
          end
        end
      end
    end

    assign value[i*OUT_WIDTH +: OUT_WIDTH] = r_val;
    assign changed[i] = r_chg;
    assign dir[i]     = r_dir;
    assign error[i]   = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_encoder_bank
// Purpose  : Scoreboard bench for quad_encoder_bank. It runs an x1 and an x4
//            instance from the same pins. Expected events are queued when
//            stimulus is issued and are popped by a monitor on each
//            changed/error pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  a, b, clear;
  logic [23:0] val1, val4;
  logic [2:0]  chg1, chg4, dir1, dir4, err1, err4;

  int checks = 0;
  int errors = 0;
  int base4;
  int e1, e4;

  typedef struct {
    int       ch;
    bit       err;
    int       val;
    bit       dir;
  } ev_t;

  ev_t exp_x1[$];
  ev_t exp_x4[$];

  always #5 clk = ~clk;

  quad_encoder_bank #(.NUM_CH(3), .OUT_WIDTH(8), .STEP(1), .FILTER_CYCLES(4), .X4_MODE(0)) u_x1 (
    .clk(clk), .reset(reset), .a(a), .b(b), .clear(clear),
    .value(val1), .changed(chg1), .dir(dir1), .error(err1)
  );

  quad_encoder_bank #(.NUM_CH(3), .OUT_WIDTH(8), .STEP(1), .FILTER_CYCLES(4), .X4_MODE(1)) u_x4 (
    .clk(clk), .reset(reset), .a(a), .b(b), .clear(clear),
    .value(val4), .changed(chg4), .dir(dir4), .error(err4)
  );

  // Queue one expected event: d=0 x1 instance, d=1 x4 instance.
  task automatic ex(input int d, input int ch, input bit err, input int val, input bit dr);
    ev_t e;
    e.ch = ch; e.err = err; e.val = val & 255; e.dir = dr;
    if (d == 0) exp_x1.push_back(e);
    else        exp_x4.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Drive one channel's {A,B} and hold for ten cycles.
  task automatic drv(input int ch, input logic [1:0] ab);
    @(negedge clk);
    a[ch] = ab[1];
    b[ch] = ab[0];
    repeat (10) @(negedge clk);
  endtask

  task automatic mon(input int d, input logic [23:0] v, input logic [2:0] cg,
                     input logic [2:0] dr, input logic [2:0] er);
    ev_t e;
    bit  empty;
    for (int c = 0; c < 3; c++) begin
      if (cg[c] || er[c]) begin
        checks++;
        empty = (d == 0) ? (exp_x1.size() == 0) : (exp_x4.size() == 0);
        if (empty) begin
          errors++;
          $display("FAIL unexpected_event dut%0d ch%0d: got chg=%0b err=%0b val=%0d, required no event",
                   d, c, cg[c], er[c], v[c*8 +: 8]);
        end else begin
          if (d == 0) e = exp_x1.pop_front();
          else        e = exp_x4.pop_front();
          if (e.ch != c || e.err != er[c] || e.err == cg[c] ||
              e.val != int'(v[c*8 +: 8]) || e.dir != dr[c]) begin
            errors++;
            $display("FAIL event dut%0d: got ch%0d chg=%0b err=%0b val=%0d dir=%0b, required ch%0d err=%0b val=%0d dir=%0b",
                     d, c, cg[c], er[c], v[c*8 +: 8], dr[c], e.ch, e.err, e.val, e.dir);
          end
        end
      end
    end
  endtask

  // Monitor: every changed/error pulse must match the next queued event.
  always @(negedge clk) begin
    if (!reset) begin
      mon(0, val1, chg1, dir1, err1);
      mon(1, val4, chg4, dir4, err4);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; a = 3'b000; b = 3'b000; clear = 3'b000;
    repeat (5) @(negedge clk);
    chk("rst_value_x1", {8'd0, val1}, 0);
    chk("rst_value_x4", {8'd0, val4}, 0);
    chk("rst_flags_x1", {chg1, dir1, err1}, 0);
    chk("rst_flags_x4", {chg4, dir4, err4}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // One forward detent on ch0.
    ex(1, 0, 0, 1, 1); drv(0, 2'b10);
    ex(1, 0, 0, 2, 1); drv(0, 2'b11);
    ex(1, 0, 0, 3, 1); drv(0, 2'b01);
    ex(0, 0, 0, 1, 1); ex(1, 0, 0, 4, 1); drv(0, 2'b00);
    chk("fwd_val0_x1", val1[7:0], 1);
    chk("fwd_val0_x4", val4[7:0], 4);
    chk("fwd_others_x1", val1[23:8], 0);
    chk("fwd_dir0_x1", dir1[0], 1);

    // One reverse detent on ch0.
    ex(1, 0, 0, 3, 0); drv(0, 2'b01);
    ex(1, 0, 0, 2, 0); drv(0, 2'b11);
    ex(1, 0, 0, 1, 0); drv(0, 2'b10);
    ex(0, 0, 0, 0, 0); ex(1, 0, 0, 0, 0); drv(0, 2'b00);
    chk("rev_val0_x4", val4[7:0], 0);
    chk("rev_dir0_x4", dir4[0], 0);

    // A two-cycle glitch on a[0] must be filtered away.
    @(negedge clk); a[0] = 1'b1;
    repeat (2) @(negedge clk); a[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_val0_x1", val1[7:0], 0);

    // A bounce 00->10->00 counts nothing in x1 and cancels in x4.
    ex(1, 0, 0, 1, 1); drv(0, 2'b10);
    ex(1, 0, 0, 0, 0); drv(0, 2'b00);
    chk("bounce_val0_x1", val1[7:0], 0);

    // A reverse detent from zero wraps, or holds at zero when saturating.
`ifdef QENC_SATURATE_EN
    drv(0, 2'b01); drv(0, 2'b11); drv(0, 2'b10); drv(0, 2'b00);
    chk("wrapdn_val0_x1", val1[7:0], 0);
    chk("wrapdn_val0_x4", val4[7:0], 0);
    ex(1, 0, 0, 1, 1); drv(0, 2'b10);
    ex(1, 0, 0, 2, 1); drv(0, 2'b11);
    ex(1, 0, 0, 3, 1); drv(0, 2'b01);
    ex(0, 0, 0, 1, 1); ex(1, 0, 0, 4, 1); drv(0, 2'b00);
    chk("wrapup_val0_x1", val1[7:0], 1);
    e1 = 1; e4 = 4;
`else
    ex(1, 0, 0, 255, 0); drv(0, 2'b01);
    ex(1, 0, 0, 254, 0); drv(0, 2'b11);
    ex(1, 0, 0, 253, 0); drv(0, 2'b10);
    ex(0, 0, 0, 255, 0); ex(1, 0, 0, 252, 0); drv(0, 2'b00);
    chk("wrapdn_val0_x1", val1[7:0], 255);
    chk("wrapdn_val0_x4", val4[7:0], 252);
    ex(1, 0, 0, 253, 1); drv(0, 2'b10);
    ex(1, 0, 0, 254, 1); drv(0, 2'b11);
    ex(1, 0, 0, 255, 1); drv(0, 2'b01);
    ex(0, 0, 0, 0, 1); ex(1, 0, 0, 0, 1); drv(0, 2'b00);
    chk("wrapup_val0_x1", val1[7:0], 0);
    e1 = 0; e4 = 0;
`endif

    // Both pins switch together: an error pulse each way, no count.
    ex(0, 0, 1, e1, 1); ex(1, 0, 1, e4, 1); drv(0, 2'b11);
    ex(0, 0, 1, e1, 1); ex(1, 0, 1, e4, 1); drv(0, 2'b00);
    chk("illegal_val0_x1", val1[7:0], e1);
    chk("illegal_val0_x4", val4[7:0], e4);

    // Set ch1 to a nonzero value, then apply clear, both idle and during a step.
    ex(1, 1, 0, 1, 1); drv(1, 2'b10);
    ex(1, 1, 0, 2, 1); drv(1, 2'b11);
    ex(1, 1, 0, 3, 1); drv(1, 2'b01);
    ex(0, 1, 0, 1, 1); ex(1, 1, 0, 4, 1); drv(1, 2'b00);
    ex(1, 1, 0, 5, 1); drv(1, 2'b10);
    @(negedge clk); clear[1] = 1'b1;
    @(negedge clk); clear[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("clear_val1_x1", val1[15:8], 0);
    chk("clear_val1_x4", val4[15:8], 0);
    chk("clear_dir1_x4", dir4[1], 1);
    @(negedge clk); clear[1] = 1'b1;
    drv(1, 2'b11);
    clear[1] = 1'b0;
    chk("clrstep_val1_x4", val4[15:8], 0);
    ex(1, 1, 0, 1, 1); drv(1, 2'b01);
    ex(1, 1, 0, 2, 1); drv(1, 2'b00);
    chk("clrstep_val1_x1", val1[15:8], 0);
    chk("clrstep_val1_x4b", val4[15:8], 2);

    // Reset during a detent with the pins resting at 11.
    base4 = e4;
    ex(1, 0, 0, base4 + 1, 1); drv(0, 2'b10);
    ex(1, 0, 0, base4 + 2, 1); drv(0, 2'b11);
    @(negedge clk); reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_value_x1", {8'd0, val1}, 0);
    chk("midrst_value_x4", {8'd0, val4}, 0);
    chk("midrst_flags_x4", {chg4, dir4, err4}, 0);
    ex(0, 0, 1, 0, 0); ex(1, 0, 1, 0, 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    ex(1, 0, 0, 1, 1); drv(0, 2'b01);
    ex(1, 0, 0, 2, 1); drv(0, 2'b00);
    ex(1, 0, 0, 3, 1); drv(0, 2'b10);
    ex(1, 0, 0, 4, 1); drv(0, 2'b11);
    ex(1, 0, 0, 5, 1); drv(0, 2'b01);
    ex(0, 0, 0, 1, 1); ex(1, 0, 0, 6, 1); drv(0, 2'b00);
    chk("postrst_val0_x1", val1[7:0], 1);
    chk("postrst_val0_x4", val4[7:0], 6);
    chk("postrst_val1_x4", val4[15:8], 0);

    repeat (20) @(negedge clk);
    chk("pending_x1", exp_x1.size(), 0);
    chk("pending_x4", exp_x4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
